stub_layer_router: RTL and testbench

// Parametrised successor of the layer router: parses a per-event stub stream (header word, packed count word, stubs)
// and steers each stub to one of N_LAYERS per-layer outputs. Adds input valid/stall, per-layer cap with drop counting,

---
 rtl/stub_router_pkg.sv | 33 +++
 rtl/pipe_delay.sv | 28 ++
 rtl/stub_layer_router.sv | 185 ++++++++++++++++++
 tb/tb_stub_layer_router.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stub_router_pkg.sv
// Shared definitions for the stub layer router: header pattern, FSM states, layer decode.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package stub_router_pkg;

  localparam logic [2:0]  HDR_TOP    = 3'b111;
  localparam logic [24:0] HDR_LOW    = 25'h1ffffff;
  localparam int          MAX_LAYERS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    ROUTE = 2'd2
  } rstate_t;

  // A header is recognised from its top three bits and its low 25 bits only.
  function automatic logic is_header(input logic [2:0] top, input logic [24:0] low);
    return (top == HDR_TOP) && (low == HDR_LOW);
  endfunction

  // The cumulative bounds are monotone, so the "stub_cnt >= bound[k]" flags form a
  // thermometer code. The number of set flags is therefore the destination layer,
  // and zero-count layers are skipped automatically.
  function automatic logic [2:0] layer_idx(input logic [MAX_LAYERS-1:0] ge);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_LAYERS; i++) begin
      if (ge[i]) idx = idx + 3'd1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth register pipeline used to delay side-band buses.
// Latency: STAGES clk.
// Backpressure: none; data advances every cycle.
module pipe_delay #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [STAGES];

  // Shift din through STAGES registers; cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[STAGES-1];

endmodule

// File: rtl/stub_layer_router.sv
// Parses header/count/stub events and steers each stub to one of N_LAYERS outputs.
// Latency: 2 clk from the cycle a stub is presented to its registered wr_en/stubout.
// Backpressure: none; stubin_valid=0 inserts a bubble, en_proc=0 freezes the parser.
module stub_layer_router
  import stub_router_pkg::*;
#(
  parameter int N_LAYERS      = 6,
  parameter int STUB_W        = 36,
  parameter int CNT_W         = 6,
  parameter int MAX_PER_LAYER = 31
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en_proc,
  input  logic [1:0]                 start,
  output logic [1:0]                 done,
  input  logic [STUB_W-1:0]          stubin,
  input  logic                       stubin_valid,
  output logic [N_LAYERS-1:0]        wr_en,
  output logic [N_LAYERS*STUB_W-1:0] stubout,
  output logic                       event_done,
  output logic                       err_trunc,
  output logic [7:0]                 drop_cnt
);

  // Bounds hold the sum of up to N_LAYERS counts, so they can never overflow.
  localparam int BND_W = CNT_W + $clog2(N_LAYERS);
  localparam int WR_W  = $clog2(MAX_PER_LAYER + 1);

  rstate_t                state;
  logic [BND_W-1:0]       bound      [N_LAYERS];
  logic [BND_W-1:0]       next_bound [N_LAYERS];
  logic [BND_W-1:0]       stub_cnt;
  logic [WR_W-1:0]        written    [N_LAYERS];
  logic [MAX_LAYERS-1:0]  ge;
  logic [2:0]             cur_layer;
  logic                   hdr;
  logic                   is_last;

  // Stage-1 pipeline registers: word, destination layer, write qualifier, event end.
  logic                   s1_vld;
  logic                   s1_done;
  logic [STUB_W-1:0]      s1_dat;
  logic [2:0]             s1_layer;

  assign hdr = is_header(stubin[STUB_W-1 -: 3], stubin[24:0]);

  // Running sum of the per-layer count fields of the incoming word (layer 0 is MSB-first).
  always_comb begin
    logic [BND_W-1:0] acc;
    acc = '0;
    for (int k = 0; k < N_LAYERS; k++) begin
      acc           = acc + BND_W'(stubin[STUB_W-1-k*CNT_W -: CNT_W]);
      next_bound[k] = acc;
    end
  end

  // One comparator per layer against the latched cumulative bounds.
  for (genvar k = 0; k < N_LAYERS; k++) begin : g_bnd
    assign ge[k] = (stub_cnt >= bound[k]);
  end
  if (N_LAYERS < MAX_LAYERS) begin : g_pad
    assign ge[MAX_LAYERS-1:N_LAYERS] = '0;
  end

  assign cur_layer = layer_idx(ge);
  assign is_last   = (stub_cnt == (bound[N_LAYERS-1] - BND_W'(1)));

  // Event parser: header/count/route FSM, per-layer caps, drop counting and stage-1 load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      stub_cnt  <= '0;
      drop_cnt  <= '0;
      err_trunc <= 1'b0;
      s1_vld    <= 1'b0;
      s1_done   <= 1'b0;
      s1_dat    <= '0;
      s1_layer  <= '0;
      for (int k = 0; k < N_LAYERS; k++) begin
        bound[k]   <= '0;
        written[k] <= '0;
      end
    end else if (en_proc) begin
      s1_vld    <= 1'b0;
      s1_done   <= 1'b0;
      err_trunc <= 1'b0;
      if (stubin_valid) begin
        case (state)
          IDLE: begin
            if (hdr) begin
              state    <= COUNT;
              drop_cnt <= '0;
            end
          end
          COUNT: begin
            if (hdr) begin
              state    <= COUNT;
              drop_cnt <= '0;
            end else begin
              bound    <= next_bound;
              stub_cnt <= '0;
              for (int k = 0; k < N_LAYERS; k++) written[k] <= '0;
              if (next_bound[N_LAYERS-1] == '0) begin
                // Empty event: finish immediately, flagged through the pipeline.
                state   <= IDLE;
                s1_done <= 1'b1;
              end else begin
                state <= ROUTE;
              end
            end
          end
          ROUTE: begin
            if (hdr) begin
              // Truncated event: abandon it and parse the new one.
              state     <= COUNT;
              err_trunc <= 1'b1;
              stub_cnt  <= '0;
              drop_cnt  <= '0;
            end else begin
              stub_cnt <= stub_cnt + BND_W'(1);
              s1_dat   <= stubin;
              s1_layer <= cur_layer;
              for (int k = 0; k < N_LAYERS; k++) begin
                if (cur_layer == 3'(k)) begin
                  if (written[k] >= WR_W'(MAX_PER_LAYER)) begin
                    if (drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
                  end else begin
                    written[k] <= written[k] + WR_W'(1);
                    s1_vld     <= 1'b1;
                  end
                end
              end
              if (is_last) begin
                state   <= IDLE;
                s1_done <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end else begin
      s1_vld    <= 1'b0;
      s1_done   <= 1'b0;
      err_trunc <= 1'b0;
    end
  end

  // Output stage: decode stage-1 into a one-hot strobe with data in the matching lane.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en      <= '0;
      stubout    <= '0;
      event_done <= 1'b0;
    end else if (en_proc) begin
      wr_en      <= '0;
      stubout    <= '0;
      event_done <= s1_done;
      if (s1_vld) begin
        for (int k = 0; k < N_LAYERS; k++) begin
          if (s1_layer == 3'(k)) begin
            wr_en[k]                     <= 1'b1;
            stubout[k*STUB_W +: STUB_W] <= s1_dat;
          end
        end
      end
    end else begin
      wr_en      <= '0;
      stubout    <= '0;
      event_done <= 1'b0;
    end
  end

  pipe_delay #(
    .WIDTH  (2),
    .STAGES (1)
  ) u_done_dly (
    .clk   (clk),
    .reset (reset),
    .din   (start),
    .dout  (done)
  );

endmodule

// File: tb/tb_stub_layer_router.sv
// Scoreboard bench for stub_layer_router: directed events, expected outputs queued at issue.
// Latency: expects each routed stub exactly 2 clk after it is presented.
// Backpressure: exercises stubin_valid bubbles and an en_proc freeze cycle.
module tb_stub_layer_router;

  localparam int NL   = 6;
  localparam int SW   = 36;
  localparam int CW   = 6;
  localparam int MAXL = 31;
  localparam logic [SW-1:0] HDR = 36'hE01FFFFFF;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             en_proc = 1'b1;
  logic [1:0]       start = 2'b00;
  logic [1:0]       done;
  logic [SW-1:0]    stubin = '0;
  logic             stubin_valid = 1'b0;
  logic [NL-1:0]    wr_en;
  logic [NL*SW-1:0] stubout;
  logic             event_done;
  logic             err_trunc;
  logic [7:0]       drop_cnt;

  stub_layer_router #(
    .N_LAYERS      (NL),
    .STUB_W        (SW),
    .CNT_W         (CW),
    .MAX_PER_LAYER (MAXL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en_proc      (en_proc),
    .start        (start),
    .done         (done),
    .stubin       (stubin),
    .stubin_valid (stubin_valid),
    .wr_en        (wr_en),
    .stubout      (stubout),
    .event_done   (event_done),
    .err_trunc    (err_trunc),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int trunc_seen = 0;
  logic [1:0] start_q = 2'b00;
  logic       rst_q = 1'b0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    start_q <= start;
    rst_q   <= reset;
  end

  typedef struct {
    int          layer;
    logic [SW-1:0] dat;
    bit          dn;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

  function automatic logic [SW-1:0] cw(input int c0, input int c1, input int c2,
                                       input int c3, input int c4, input int c5);
    return {6'(c0), 6'(c1), 6'(c2), 6'(c3), 6'(c4), 6'(c5)};
  endfunction

  function automatic logic [SW-1:0] stub(input int i);
    return 36'h1A5000000 + SW'(i);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Drive one word for one sample edge; queue the output it must produce 2 clk later.
  task automatic send(input logic [SW-1:0] w, input bit v, input int lay, input bit dn,
                      input bit en = 1'b1);
    exp_t e;
    @(posedge clk);
    #1;
    stubin       = w;
    stubin_valid = v;
    en_proc      = en;
    start        = 2'(cyc);
    if (lay >= 0 || dn) begin
      e.layer = lay;
      e.dat   = w;
      e.dn    = dn;
      e.cyc   = cyc + 2;
      exp_q.push_back(e);
    end
  endtask

  task automatic bubble();
    send(HDR, 1'b0, -1, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) bubble();
  endtask

  // Counts 2,1,0,3,0,1: S0,S1->L0, S2->L1, S3..S5->L3, S6->L5 with event_done.
  task automatic ev_basic(input bit bub, input int base);
    int lay[7] = '{0, 0, 1, 3, 3, 3, 5};
    send(HDR, 1'b1, -1, 1'b0);
    if (bub) bubble();
    send(cw(2, 1, 0, 3, 0, 1), 1'b1, -1, 1'b0);
    if (bub) begin
      bubble();
      send(stub(999), 1'b1, -1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 7; i++) begin
      send(stub(base + i), 1'b1, lay[i], i == 6);
      if (bub && i < 6) bubble();
    end
    bubble();
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or event_done.
  exp_t           me;
  logic [NL-1:0]  mw;
  logic [NL*SW-1:0] mo;
  always @(negedge clk) begin
    if (reset) begin
      if (wr_en != '0 || event_done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: wr_en=%b event_done=%b cyc=%0d, required no output",
                   wr_en, event_done, cyc);
        end else begin
          me = exp_q.pop_front();
          mw = '0;
          mo = '0;
          if (me.layer >= 0) begin
            mw[me.layer] = 1'b1;
            mo[me.layer*SW +: SW] = me.dat;
          end
          if (wr_en !== mw || stubout !== mo || event_done !== me.dn || cyc != me.cyc) begin
            errors++;
            $display("FAIL out: got wr_en=%b done=%b cyc=%0d data=%h, required wr_en=%b done=%b cyc=%0d data=%h",
                     wr_en, event_done, cyc, stubout, mw, me.dn, me.cyc, mo);
          end
        end
      end else begin
        checks++;
        if (stubout !== '0) begin
          errors++;
          $display("FAIL stubout_idle: got %h, required 0", stubout);
        end
      end
      if (err_trunc) trunc_seen++;
      if (rst_q) begin
        checks++;
        if (done !== start_q) begin
          errors++;
          $display("FAIL done_delay: got %b, required %b", done, start_q);
        end
      end
    end
  end

  initial begin
    #1 reset = 1'b0;
    #1;
    check("rst_wr_en",      64'(wr_en),      64'd0);
    check("rst_stubout",    64'(stubout != '0), 64'd0);
    check("rst_event_done", 64'(event_done), 64'd0);
    check("rst_err_trunc",  64'(err_trunc),  64'd0);
    check("rst_drop_cnt",   64'(drop_cnt),   64'd0);
    check("rst_done",       64'(done),       64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    // Basic routing, then the same event with bubbles and an en_proc freeze cycle.
    ev_basic(1'b0, 0);
    idle(3);
    check("drop_after_basic", 64'(drop_cnt), 64'd0);
    ev_basic(1'b1, 16);
    idle(3);

    // Cap: L0 gets 40 stubs, only 31 are written, 9 dropped; L1 and L5 still routed.
    send(HDR, 1'b1, -1, 1'b0);
    send(cw(40, 2, 0, 0, 0, 1), 1'b1, -1, 1'b0);
    for (int i = 0; i < 43; i++) begin
      if (i < 31)      send(stub(100 + i), 1'b1, 0, 1'b0);
      else if (i < 40) send(stub(100 + i), 1'b1, -1, 1'b0);
      else if (i < 42) send(stub(100 + i), 1'b1, 1, 1'b0);
      else             send(stub(100 + i), 1'b1, 5, 1'b1);
    end
    idle(4);
    check("drop_cnt_cap", 64'(drop_cnt), 64'd9);

    // Truncation: header after 3 of 7 stubs, repeated header, then a new event.
    send(HDR, 1'b1, -1, 1'b0);
    send(cw(2, 1, 0, 3, 0, 1), 1'b1, -1, 1'b0);
    check("drop_cleared_hdr", 64'(drop_cnt), 64'd0);
    send(stub(200), 1'b1, 0, 1'b0);
    send(stub(201), 1'b1, 0, 1'b0);
    send(stub(202), 1'b1, 1, 1'b0);
    send(HDR, 1'b1, -1, 1'b0);
    send(HDR, 1'b1, -1, 1'b0);
    send(cw(0, 0, 1, 0, 2, 0), 1'b1, -1, 1'b0);
    send(stub(210), 1'b1, 2, 1'b0);
    send(stub(211), 1'b1, 4, 1'b0);
    send(stub(212), 1'b1, 4, 1'b1);
    idle(3);

    // All-zero count word: event_done alone, 2 clk after the count word.
    send(HDR, 1'b1, -1, 1'b0);
    send(cw(0, 0, 0, 0, 0, 0), 1'b1, -1, 1'b1);
    idle(3);

    // Reset while a write is on the outputs and another stub is in flight.
    send(HDR, 1'b1, -1, 1'b0);
    send(cw(2, 1, 0, 3, 0, 1), 1'b1, -1, 1'b0);
    send(stub(300), 1'b1, 0, 1'b0);
    send(stub(301), 1'b1, -1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
    stubin_valid = 1'b0;
    #1;
    check("midrst_wr_en",      64'(wr_en),      64'd0);
    check("midrst_stubout",    64'(stubout != '0), 64'd0);
    check("midrst_event_done", 64'(event_done), 64'd0);
    check("midrst_drop_cnt",   64'(drop_cnt),   64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // After reset the parser is idle: a lone stub is ignored, then a full event routes.
    send(stub(400), 1'b1, -1, 1'b0);
    bubble();
    ev_basic(1'b0, 32);
    idle(4);

    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("err_trunc_pulses", 64'(trunc_seen), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
